// File: rtl/pic16_timer_pkg.sv
// Shared definitions for the PIC16C57 timer block.
// Contents:
//   OPT_*    bit positions inside the 6-bit OPTION register
//   ps_mask  prescaler ratio minus one (R-1) for a given PS/PSA pair
package pic16_timer_pkg;

  localparam int unsigned OPT_T0CS   = 5;
  localparam int unsigned OPT_T0SE   = 4;
  localparam int unsigned OPT_PSA    = 3;
  localparam int unsigned OPT_PS_MSB = 2;

  // R = 2^(PS+1) when assigned to TMR0, R = 2^PS when assigned to the WDT.
  // Returned as R-1 so the prescaler can test for a wrap with a simple AND.
  function automatic logic [7:0] ps_mask(input logic [2:0] ps, input logic psa);
    logic [8:0] ratio;
    if (psa) begin
      ratio = 9'd1 << ps;
    end else begin
      ratio = 9'd2 << ps;
    end
    return 8'(ratio - 9'd1);
  endfunction

endpackage

// File: rtl/t0cki_sync.sv
// Synchroniser and edge detector for the asynchronous T0CKI pin.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_t0cki     raw external timer clock
//   i_t0se      0 = rising edge, 1 = falling edge
//   o_event     one-clk strobe, high in the cycle before the third clk edge after the pin moved
module t0cki_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_t0cki,
  input  logic i_t0se,
  output logic o_event
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_t0cki;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Edge polarity is chosen live, so a T0SE change takes effect immediately.
  always_comb begin
    o_event = 1'b0;
    if (i_t0se) begin
      o_event = r_prev & ~r_sync2;
    end else begin
      o_event = ~r_prev & r_sync2;
    end
  end

endmodule

// File: rtl/tmr0_wdt_ctrl.sv
// Timer0 and watchdog controller for the PIC16C57 core.
// Owns TMR0, the WDT base divider and the shared 8-bit prescaler (assigned by OPTION.PSA).
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   inst_cycle        one-clk strobe per instruction cycle
//   option_in         OPTION: [5]=T0CS [4]=T0SE [3]=PSA [2:0]=PS
//   wdte              watchdog enable fuse
//   T0CKI             external timer clock (asynchronous)
//   tmr0_we/_wdata    TMR0 write port
//   clear_WDT         CLRWDT/SLEEP executed
//   clear_prescaler   unconditional prescaler clear
//   sleep             core sleeping; freezes the TMR0 path only
//   TMR0_out          current TMR0 value
//   tmr0_ovf          one-clk pulse with the FF->00 update
//   WDT_timeout       one-clk watchdog timeout pulse
module tmr0_wdt_ctrl
  import pic16_timer_pkg::*;
#(
  parameter int unsigned WDT_BASE_CYCLES = 18000,
  parameter int unsigned WDT_DIV_W       = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inst_cycle,
  input  logic [5:0] option_in,
  input  logic       wdte,
  input  logic       T0CKI,
  input  logic       tmr0_we,
  input  logic [7:0] tmr0_wdata,
  input  logic       clear_WDT,
  input  logic       clear_prescaler,
  input  logic       sleep,
  output logic [7:0] TMR0_out,
  output logic       tmr0_ovf,
  output logic       WDT_timeout
);

  localparam logic [WDT_DIV_W-1:0] DivLast = WDT_DIV_W'(WDT_BASE_CYCLES - 1);

  logic [7:0]           r_tmr0;
  logic [7:0]           r_pre;
  logic [WDT_DIV_W-1:0] r_div;
  logic [1:0]           r_inhibit;
  logic                 r_ovf;
  logic                 r_wdt_to;

  logic [7:0]           w_tmr0_d;
  logic [7:0]           w_pre_d;
  logic [WDT_DIV_W-1:0] w_div_d;
  logic [1:0]           w_inhibit_d;
  logic                 w_ovf_d;
  logic                 w_wdt_to_d;

  logic       w_t0cs;
  logic       w_t0se;
  logic       w_psa;
  logic [2:0] w_ps;
  logic [7:0] w_mask;
  logic [7:0] w_pre_inc;
  logic       w_ext_evt;
  logic       w_src_evt;
  logic       w_tmr_evt;
  logic       w_base_tick;
  logic       w_pre_evt;
  logic       w_pre_fire;
  logic       w_tmr_inc;

  assign w_t0cs = option_in[OPT_T0CS];
  assign w_t0se = option_in[OPT_T0SE];
  assign w_psa  = option_in[OPT_PSA];
  assign w_ps   = option_in[OPT_PS_MSB:0];
  assign w_mask = ps_mask(w_ps, w_psa);

  t0cki_sync u_t0cki_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_t0cki (T0CKI),
    .i_t0se  (w_t0se),
    .o_event (w_ext_evt)
  );

  // Event qualification and prescaler firing.
  always_comb begin
    w_src_evt   = w_t0cs ? w_ext_evt : inst_cycle;
    // TMR0 events are dropped while asleep or in the post-write inhibit window.
    w_tmr_evt   = w_src_evt & ~sleep & (r_inhibit == 2'd0);
    // A CLRWDT landing on the tick clk swallows the tick.
    w_base_tick = wdte & (r_div == DivLast) & ~clear_WDT;
    w_pre_evt   = w_psa ? w_base_tick : w_tmr_evt;
    w_pre_inc   = r_pre + 8'd1;
    w_pre_fire  = w_pre_evt & ~clear_prescaler & ((w_pre_inc & w_mask) == 8'd0);
    w_tmr_inc   = w_psa ? w_tmr_evt : w_pre_fire;
  end

  // Prescaler next state; every clear source outranks counting.
  always_comb begin
    w_pre_d = r_pre;
    if (clear_prescaler || (tmr0_we && !w_psa) || (clear_WDT && w_psa)) begin
      w_pre_d = 8'd0;
    end else if (w_pre_evt) begin
      // Return to zero on fire so a ratio change never leaves a stale offset behind.
      w_pre_d = w_pre_fire ? 8'd0 : w_pre_inc;
    end
  end

  // TMR0, overflow pulse and inhibit window.
  always_comb begin
    w_tmr0_d    = r_tmr0;
    w_ovf_d     = 1'b0;
    w_inhibit_d = r_inhibit;
    if (tmr0_we) begin
      w_tmr0_d    = tmr0_wdata;
      w_inhibit_d = 2'd2;
    end else begin
      if (w_tmr_inc) begin
        w_tmr0_d = r_tmr0 + 8'd1;
        w_ovf_d  = (r_tmr0 == 8'hFF);
      end
      if (inst_cycle && !sleep && (r_inhibit != 2'd0)) begin
        w_inhibit_d = r_inhibit - 2'd1;
      end
    end
  end

  // Watchdog base divider and timeout; this path keeps running during sleep.
  always_comb begin
    w_div_d    = r_div + WDT_DIV_W'(1);
    w_wdt_to_d = w_psa ? w_pre_fire : w_base_tick;
    if (!wdte || clear_WDT || (r_div == DivLast)) begin
      w_div_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr0    <= 8'd0;
      r_pre     <= 8'd0;
      r_div     <= '0;
      r_inhibit <= 2'd0;
      r_ovf     <= 1'b0;
      r_wdt_to  <= 1'b0;
    end else begin
      r_tmr0    <= w_tmr0_d;
      r_pre     <= w_pre_d;
      r_div     <= w_div_d;
      r_inhibit <= w_inhibit_d;
      r_ovf     <= w_ovf_d;
      r_wdt_to  <= w_wdt_to_d;
    end
  end

  assign TMR0_out    = r_tmr0;
  assign tmr0_ovf    = r_ovf;
  assign WDT_timeout = r_wdt_to;

endmodule

// File: doc/tmr0_wdt_ctrl.md
Name: tmr0_wdt_ctrl

Overview:
Timer0 and watchdog controller for the PIC16C57 core. It owns the TMR0 counter, the WDT base divider and the single 8-bit prescaler. Per OPTION.PSA, the prescaler is assigned to either TMR0 or the WDT. It sits beside data_path and control_unit. It consumes OPTION_out, clear_WDT, clear_prescaler and sleep, and produces TMR0_out and WDT_timeout for the top-level reset logic.

Parameters:
WDT_BASE_CYCLES, 18000, clk cycles per WDT base tick (nominal 18 ms period); minimum 2.
WDT_DIV_W, 15, width of the base divider counter; must hold WDT_BASE_CYCLES-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
inst_cycle  in  1  one-clk strobe per instruction cycle
option_in  in  6  OPTION: [5]=T0CS, [4]=T0SE, [3]=PSA, [2:0]=PS
wdte  in  1  WDT enable fuse; 0 disables the watchdog
T0CKI  in  1  external timer clock, asynchronous
tmr0_we  in  1  write strobe for TMR0 (MOVWF TMR0 etc.)
tmr0_wdata  in  8  write data
clear_WDT  in  1  CLRWDT/SLEEP executed
clear_prescaler  in  1  unconditional prescaler clear
sleep  in  1  core in sleep
TMR0_out  out  8  TMR0 value
tmr0_ovf  out  1  one-clk pulse on FF->00 increment
WDT_timeout  out  1  one-clk timeout pulse

Behaviour:
- Reset (async, rst_n=0): TMR0=0, prescaler=0, base divider=0, inhibit=0, sync flops=0; all outputs 0.
- T0CKI handling: 2-FF synchroniser plus edge detector.
  - T0SE=0 selects rising edge; T0SE=1 selects falling edge.
  - The edge event is valid 3 clk after the pin transition.
- TMR0 source event:
  - T0CS=0: inst_cycle.
  - T0CS=1: T0CKI edge event.
  - Events are ignored while sleep=1 or inhibit!=0.
- Prescaler ratio R:
  - PSA=0 (TMR0): R=2^(PS+1), range 2..256.
  - PSA=1 (WDT): R=2^PS, range 1..128.
- Prescaler output: the prescaler increments on each event from its assigned source. It fires on the event where (pre_cnt+1) mod R == 0. R=1 fires on every event.
- TMR0 increment:
  - PSA=0: on prescaler output.
  - PSA=1: on every source event.
  - Wrap FF->00 pulses tmr0_ovf in the same clk as the update.
- TMR0 write (tmr0_we=1):
  - Loads tmr0_wdata next clk and sets inhibit=2.
  - Inhibit decrements on each inst_cycle; TMR0 increments are suppressed while inhibit!=0.
  - If PSA=0, the prescaler is also cleared.
  - A write in the same clk as an increment: the write wins.
- WDT base divider:
  - Counts every clk while wdte=1, including during sleep.
  - Produces a base tick at count WDT_BASE_CYCLES-1, then returns to 0.
  - Held at 0 while wdte=0.
- WDT_timeout:
  - PSA=0: pulses on each base tick.
  - PSA=1: pulses on prescaler output driven by base ticks.
  - After the pulse, the base divider and prescaler (if PSA=1) are already at 0.
- clear_WDT: clears the base divider, and the prescaler if PSA=1. A clear in the same clk as a base tick wins; no timeout that clk.
- clear_prescaler: clears the prescaler regardless of PSA. It has priority over a same-clk prescaler increment.
- PSA or PS change mid-count: the prescaler keeps its count. The new assignment and ratio apply from the next event. Software issues CLRWDT before reassigning.
- Sleep: TMR0, prescaler (if PSA=0) and inhibit are frozen. The WDT path keeps running, and its timeout is the wake source.

Decomposition:
- Package pic16_timer_pkg holds:
  - OPTION bit indices: OPT_T0CS=5, OPT_T0SE=4, OPT_PSA=3, OPT_PS_MSB=2.
  - Function ps_mask(PS, PSA) returning R-1 as 8 bits.
- Sub-module t0cki_sync: 2-FF synchroniser plus T0SE-selected edge detect, outputting a one-clk event.
- Prescaler, TMR0 and WDT logic stay in tmr0_wdt_ctrl.

Test Plan:
- Reset: rst_n low mid-count with TMR0=0x37 -> TMR0_out=0, tmr0_ovf=0 and WDT_timeout=0 immediately (asynchronous).
- option_in=6'b000001 (timer mode, PSA=0, 1:4), 8 inst_cycle strobes -> TMR0_out=2, increment only on strobes 4 and 8.
- option_in=6'b001000 (PSA=1, TMR0 1:1); write 0xFE, then 4 strobes -> strobes 1-2 ignored, strobe 3 gives 0xFF, strobe 4 gives 0x00 with a one-clk tmr0_ovf pulse.
- WDT_BASE_CYCLES=10, wdte=1, option_in=6'b001010 (PSA=1, 1:4) -> WDT_timeout pulse at clk 40 after reset release. Repeat with clear_WDT at clk 35 -> next pulse at clk 75.
- option_in=6'b111000 (counter mode, falling edge, PSA=1); 3 full T0CKI pulses -> TMR0=3, each increment 3 clk after its falling edge, none on rising edges.
- sleep=1 with 20 strobes and WDT_BASE_CYCLES=10, PSA=0 -> TMR0 unchanged, WDT_timeout pulses every 10 clk. Same with wdte=0 -> no pulses.
